// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and key decoding for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;
  localparam logic [3:0] COLS_RESET = 4'b1110;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    return KEYMAP[{row, col, 2'b00} +: 4];
  endfunction
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) if (!v[i]) idx = 2'(i);
    return idx;
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running prescaler emitting a one-cycle tick on each wrap
module scan_tick_gen #(
  parameter int SCAN_DIV = 15
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  logic [SCAN_DIV-1:0] pre;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre <= '0;
      tick <= 1'b0;
    end else begin
      pre <= pre + SCAN_DIV'(1);
      tick <= &pre;
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan, debounce, decode and 4-digit shift register
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 15,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rows_n,
  output logic [3:0]  cols_n,
  input  logic        clear,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] dout
);
  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);
  logic tick, single;
  logic [3:0] rs_meta, rs, pat, cnt, cnt_inc, code;
  logic [1:0] row, col;
  state_t state;
  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));
  always_comb begin
    single = $countones(~rs) == 1;
    pat = ~(4'd1 << row);
    cnt_inc = &cnt ? cnt : cnt + 4'd1;
    code = keymap(row, col);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rs_meta <= ROWS_IDLE;
      rs <= ROWS_IDLE;
      cols_n <= COLS_RESET;
      state <= SCAN;
      cnt <= '0;
      row <= '0;
      col <= '0;
      key_valid <= 1'b0;
      key_code <= '0;
      dout <= '0;
    end else begin
      rs_meta <= rows_n;
      rs <= rs_meta;
      key_valid <= 1'b0;
      if (tick)
        case (state)
          SCAN:
            if (single) begin
              row <= low_idx(rs);
              col <= low_idx(cols_n);
              cnt <= 4'd1;
              state <= DEBOUNCE;
            end else cols_n <= {cols_n[2:0], cols_n[3]};
          DEBOUNCE:
            if (rs != pat) state <= SCAN;
            else if (cnt_inc >= DS) begin
              key_valid <= 1'b1;
              key_code <= code;
              dout <= {dout[11:0], code};
              cnt <= '0;
              state <= HOLD;
            end else cnt <= cnt_inc;
          HOLD:
            if (rs != ROWS_IDLE) cnt <= '0;
            else if (cnt_inc >= DS) begin
              cnt <= '0;
              state <= SCAN;
            end else cnt <= cnt_inc;
          default: state <= SCAN;
        endcase
      if (clear) dout <= '0;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench driving a keypad matrix model into keypad_scanner
module tb_keypad_scanner;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, key_valid;
  logic [3:0] rows_n, cols_n, key_code;
  logic [15:0] dout, pressed = '0, exp_dout = '0;
  logic [19:0] sb[$];
  logic prev_kv = 1'b0;
  int total = 0, bad = 0, pulses = 0;
  keypad_scanner #(.SCAN_DIV(2), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst_n(rst_n), .rows_n(rows_n), .cols_n(cols_n), .clear(clear),
    .key_valid(key_valid), .key_code(key_code), .dout(dout)
  );
  always #5 clk = ~clk;
  always_comb begin
    rows_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
  end
  always @(negedge clk) begin
    logic [19:0] e;
    if (rst_n && key_valid) begin
      pulses++;
      total++;
      if (prev_kv) begin bad++; $display("FAIL pulse_width: key_valid high two cycles in a row"); end
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse: got key_code=%h dout=%h, none expected", key_code, dout);
      end else begin
        e = sb.pop_front();
        total += 2;
        if (key_code !== e[19:16]) begin bad++; $display("FAIL key_code: got %h want %h", key_code, e[19:16]); end
        if (dout !== e[15:0]) begin bad++; $display("FAIL dout_on_pulse: got %h want %h", dout, e[15:0]); end
      end
    end
    prev_kv = key_valid;
  end
  task automatic expect_key(input logic [3:0] code);
    exp_dout = {exp_dout[11:0], code};
    sb.push_back({code, exp_dout});
  endtask
  task automatic press_key(input int r, input int c, input logic [3:0] code);
    expect_key(code);
    pressed[r*4+c] = 1'b1;
    repeat (40) @(negedge clk);
    pressed = '0;
    repeat (40) @(negedge clk);
  endtask
  task automatic wait_cols(input logic [3:0] v, input string name);
    int n;
    n = 0;
    while (cols_n !== v && n < 40) begin @(negedge clk); n++; end
    if (cols_n !== v) begin total++; bad++; $display("FAIL %s: cols_n=%b never reached %b", name, cols_n, v); end
  endtask
  task automatic wait_fresh_c0();
    int n;
    n = 0;
    while (cols_n === 4'b1110 && n < 20) begin @(negedge clk); n++; end
    wait_cols(4'b1110, "fresh_c0");
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 4;
    if (cols_n !== 4'b1110) begin bad++; $display("FAIL reset_cols: got %b want 1110", cols_n); end
    if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    if (key_code !== 4'h0) begin bad++; $display("FAIL reset_code: got %h want 0", key_code); end
    if (dout !== 16'h0) begin bad++; $display("FAIL reset_dout: got %h want 0000", dout); end
    rst_n = 1'b1;
  endtask
  task automatic test_idle();
    logic [3:0] seq [5];
    logic [3:0] last;
    int n, dt;
    seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    for (int i = 0; i < 5; i++) begin
      last = cols_n;
      n = 0;
      while (cols_n === last && n < 12) begin @(negedge clk); n++; end
      dt = n;
      total++;
      if (cols_n !== seq[i]) begin bad++; $display("FAIL idle_rotate%0d: got %b want %b", i, cols_n, seq[i]); end
      if (i > 0) begin
        total++;
        if (dt != 4) begin bad++; $display("FAIL idle_period%0d: got %0d clk want 4", i, dt); end
      end
    end
    total++;
    if (dout !== 16'h0) begin bad++; $display("FAIL idle_dout: got %h want 0000", dout); end
  endtask
  task automatic test_single_key();
    int p0;
    logic moved;
    p0 = pulses;
    expect_key(4'h6);
    pressed[1*4+2] = 1'b1;
    repeat (40) @(negedge clk);
    pressed = '0;
    repeat (6) @(negedge clk);
    total += 4;
    if (pulses - p0 != 1) begin bad++; $display("FAIL single_count: got %0d pulses want 1", pulses - p0); end
    if (key_code !== 4'h6) begin bad++; $display("FAIL single_code: got %h want 6", key_code); end
    if (dout !== 16'h0006) begin bad++; $display("FAIL single_dout: got %h want 0006", dout); end
    if (cols_n !== 4'b1011) begin bad++; $display("FAIL single_hold: cols_n=%b want 1011", cols_n); end
    moved = 1'b0;
    repeat (34) begin @(negedge clk); if (cols_n !== 4'b1011) moved = 1'b1; end
    total++;
    if (!moved) begin bad++; $display("FAIL single_resume: cols_n stuck at %b want rotation", cols_n); end
  endtask
  task automatic test_sequence();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_dout = '0;
    total++;
    if (dout !== 16'h0) begin bad++; $display("FAIL seq_clear: got %h want 0000", dout); end
    press_key(0, 0, 4'h1);
    press_key(0, 1, 4'h2);
    press_key(0, 2, 4'h3);
    press_key(0, 3, 4'hA);
    press_key(1, 1, 4'h5);
    total++;
    if (dout !== 16'h23A5) begin bad++; $display("FAIL seq_dout: got %h want 23A5", dout); end
  endtask
  task automatic test_bounce();
    int p0;
    wait_fresh_c0();
    p0 = pulses;
    expect_key(4'h1);
    pressed[0] = 1'b1;
    repeat (4) @(negedge clk);
    pressed = '0;
    repeat (4) @(negedge clk);
    total++;
    if (pulses != p0) begin bad++; $display("FAIL bounce_glitch: got %0d pulses want 0", pulses - p0); end
    pressed[0] = 1'b1;
    repeat (40) @(negedge clk);
    pressed = '0;
    repeat (40) @(negedge clk);
    total += 2;
    if (pulses - p0 != 1) begin bad++; $display("FAIL bounce_count: got %0d pulses want 1", pulses - p0); end
    if (key_code !== 4'h1) begin bad++; $display("FAIL bounce_code: got %h want 1", key_code); end
  endtask
  task automatic test_two_keys();
    int p0, changes;
    logic [3:0] last;
    p0 = pulses;
    pressed[0*4+1] = 1'b1;
    pressed[2*4+1] = 1'b1;
    repeat (40) @(negedge clk);
    changes = 0;
    repeat (20) begin last = cols_n; @(negedge clk); if (cols_n !== last) changes++; end
    total += 2;
    if (pulses != p0) begin bad++; $display("FAIL two_keys_pulse: got %0d pulses want 0", pulses - p0); end
    if (changes < 3) begin bad++; $display("FAIL two_keys_rotate: got %0d column changes want >=3", changes); end
    expect_key(4'h2);
    pressed[2*4+1] = 1'b0;
    repeat (40) @(negedge clk);
    pressed = '0;
    repeat (40) @(negedge clk);
    total += 2;
    if (pulses - p0 != 1) begin bad++; $display("FAIL two_keys_release: got %0d pulses want 1", pulses - p0); end
    if (key_code !== 4'h2) begin bad++; $display("FAIL two_keys_code: got %h want 2", key_code); end
  endtask
  task automatic test_clear_on_pulse();
    int n;
    clear = 1'b1;
    exp_dout = '0;
    sb.push_back({4'h9, 16'h0000});
    pressed[2*4+2] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    clear = 1'b0;
    total++;
    if (key_valid !== 1'b1) begin bad++; $display("FAIL clear_wait: key_valid=%b want 1 within 100 clk", key_valid); end
    repeat (40) @(negedge clk);
    pressed = '0;
    repeat (40) @(negedge clk);
    total += 2;
    if (key_code !== 4'h9) begin bad++; $display("FAIL clear_code: got %h want 9", key_code); end
    if (dout !== 16'h0) begin bad++; $display("FAIL clear_dout: got %h want 0000", dout); end
    press_key(3, 2, 4'hF);
    total++;
    if (dout !== 16'h000F) begin bad++; $display("FAIL clear_after: got %h want 000F", dout); end
  endtask
  task automatic test_reset_mid();
    int p0;
    wait_fresh_c0();
    pressed[3*4+3] = 1'b1;
    wait_cols(4'b0111, "mid_reach_c3");
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total += 4;
    if (cols_n !== 4'b1110) begin bad++; $display("FAIL mid_cols: got %b want 1110", cols_n); end
    if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", key_valid); end
    if (key_code !== 4'h0) begin bad++; $display("FAIL mid_code: got %h want 0", key_code); end
    if (dout !== 16'h0) begin bad++; $display("FAIL mid_dout: got %h want 0000", dout); end
    pressed = '0;
    exp_dout = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    repeat (60) @(negedge clk);
    total += 2;
    if (pulses != p0) begin bad++; $display("FAIL mid_no_pulse: got %0d pulses want 0", pulses - p0); end
    if (dout !== 16'h0) begin bad++; $display("FAIL mid_dout_after: got %h want 0000", dout); end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_idle();
    test_single_key();
    test_sequence();
    test_bounce();
    test_two_keys();
    test_clear_on_pulse();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain: %0d expected keys never seen", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
